// File: rtl/alarm_ringer.sv
// Alarm ringer FSM: rings, snoozes and dismisses an alarm event with registered outputs.
// Define ALARM_RINGER_PATTERN_EN to make the buzzer beep at BEEP_HALF clk half-periods instead of sounding steadily.
module alarm_ringer #(
    parameter int BEEP_HALF         = 4,
    parameter int RING_TIMEOUT_SECS = 60,
    parameter int SNOOZE_SECS       = 300,
    parameter int MAX_SNOOZE        = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       buzz_req,
    input  logic       snooze,
    input  logic       dismiss,
    output logic       buzzer_out,
    output logic       ringing,
    output logic       dismiss_ack,
    output logic [1:0] snooze_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_TIMEOUT_SECS - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] COUNT_MAX   = 2'(MAX_SNOOZE);

    // Out-of-range parameters stop elaboration rather than silently truncating.
    if (BEEP_HALF < 1 || BEEP_HALF > 65535) begin : g_bad_beep_half
        $error("alarm_ringer: BEEP_HALF out of range");
    end
    if (RING_TIMEOUT_SECS < 1 || RING_TIMEOUT_SECS > 511) begin : g_bad_ring_timeout
        $error("alarm_ringer: RING_TIMEOUT_SECS out of range");
    end
    if (SNOOZE_SECS < 1 || SNOOZE_SECS > 511) begin : g_bad_snooze_secs
        $error("alarm_ringer: SNOOZE_SECS out of range");
    end
    if (MAX_SNOOZE < 0 || MAX_SNOOZE > 3) begin : g_bad_max_snooze
        $error("alarm_ringer: MAX_SNOOZE out of range");
    end

    state_t     state_q, state_d;
    logic [8:0] sec_cnt_q, sec_cnt_d;
    logic [1:0] count_d;
    logic       buzz_d;
    logic       ack_d;
    logic       can_snooze;
    logic       ring_timeout;
    logic       snooze_expire;
    logic       state_change;

    assign can_snooze    = (snooze_count < COUNT_MAX);
    assign ring_timeout  = tick_1hz && (sec_cnt_q == RING_LAST);
    assign snooze_expire = tick_1hz && (sec_cnt_q == SNOOZE_LAST);
    assign state_change  = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        count_d = snooze_count;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (buzz_req) state_d = RING;
            end
            RING: begin
                // Dropped alarm beats dismiss beats snooze beats timeout.
                if (!buzz_req) begin
                    state_d = IDLE;
                end else if (dismiss) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end else if (snooze && can_snooze) begin
                    state_d = SNOOZE;
                    count_d = snooze_count + 2'd1;
                end else if (ring_timeout) begin
                    if (can_snooze) begin
                        state_d = SNOOZE;
                        count_d = snooze_count + 2'd1;
                    end else begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (dismiss) begin
                    state_d = DONE;
                    ack_d   = 1'b1;
                end else if (snooze_expire) begin
                    state_d = buzz_req ? RING : IDLE;
                end
            end
            DONE: begin
                if (!buzz_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) count_d = 2'd0;

        sec_cnt_d = sec_cnt_q;
        if (state_change) begin
            sec_cnt_d = 9'd0;
        end else if (tick_1hz && (state_q == RING || state_q == SNOOZE)) begin
            sec_cnt_d = sec_cnt_q + 9'd1;
        end
    end

`ifdef ALARM_RINGER_PATTERN_EN
    localparam logic [15:0] BEEP_LAST = 16'(BEEP_HALF - 1);

    logic [15:0] beep_cnt_q, beep_cnt_d;

    // Entering RING starts a fresh "on" half-period; each half lasts BEEP_HALF cycles.
    always_comb begin
        beep_cnt_d = 16'd0;
        buzz_d     = 1'b0;
        if (state_d == RING) begin
            if (state_change) begin
                buzz_d = 1'b1;
            end else if (beep_cnt_q == BEEP_LAST) begin
                buzz_d = ~buzzer_out;
            end else begin
                beep_cnt_d = beep_cnt_q + 16'd1;
                buzz_d     = buzzer_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) beep_cnt_q <= 16'd0;
        else       beep_cnt_q <= beep_cnt_d;
    end
`else
    always_comb buzz_d = (state_d == RING);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sec_cnt_q    <= 9'd0;
            snooze_count <= 2'd0;
            buzzer_out   <= 1'b0;
            ringing      <= 1'b0;
            dismiss_ack  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_count <= count_d;
            buzzer_out   <= buzz_d;
            ringing      <= (state_d == RING);
            dismiss_ack  <= ack_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: directed scenarios followed by random stimulus checked against a behavioural model.
module tb_alarm_ringer;

    localparam int BH = 4;
    localparam int TO = 5;
    localparam int SN = 3;
    localparam int MX = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       buzz_req = 1'b0;
    logic       snooze = 1'b0;
    logic       dismiss = 1'b0;
    logic       buzzer_out;
    logic       ringing;
    logic       dismiss_ack;
    logic [1:0] snooze_count;
    logic [1:0] state;

    alarm_ringer #(
        .BEEP_HALF(BH),
        .RING_TIMEOUT_SECS(TO),
        .SNOOZE_SECS(SN),
        .MAX_SNOOZE(MX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick_1hz(tick_1hz),
        .buzz_req(buzz_req),
        .snooze(snooze),
        .dismiss(dismiss),
        .buzzer_out(buzzer_out),
        .ringing(ringing),
        .dismiss_ack(dismiss_ack),
        .snooze_count(snooze_count),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       buzz;
        logic       ring;
        logic       ack;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: mode 0=idle 1=ring 2=snooze 3=done; the buzzer is derived from time spent ringing.
    int m_mode = 0;
    int m_secs = 0;
    int m_ring_cyc = 0;
    int m_cnt = 0;
    bit m_ack = 0;

    task automatic model_step(input bit r, input bit b, input bit t, input bit s, input bit d);
        int prev;
        prev  = m_mode;
        m_ack = 0;
        if (r) begin
            m_mode = 0;
            m_cnt  = 0;
        end else begin
            case (m_mode)
                0: if (b) m_mode = 1;
                1: begin
                    if (!b) m_mode = 0;
                    else if (d) begin m_mode = 3; m_ack = 1; end
                    else if (s && m_cnt < MX) begin m_mode = 2; m_cnt++; end
                    else if (t && m_secs + 1 == TO) begin
                        if (m_cnt < MX) begin m_mode = 2; m_cnt++; end
                        else begin m_mode = 3; m_ack = 1; end
                    end else begin
                        if (t) m_secs++;
                        m_ring_cyc++;
                    end
                end
                2: begin
                    if (d) begin m_mode = 3; m_ack = 1; end
                    else if (t && m_secs + 1 == SN) m_mode = b ? 1 : 0;
                    else if (t) m_secs++;
                end
                default: if (!b) m_mode = 0;
            endcase
        end
        if (r || m_mode != prev) begin
            m_secs     = 0;
            m_ring_cyc = 0;
        end
        if (m_mode == 0) m_cnt = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.st   = 2'(m_mode);
        e.ring = (m_mode == 1);
        e.ack  = m_ack;
        e.cnt  = 2'(m_cnt);
`ifdef ALARM_RINGER_PATTERN_EN
        e.buzz = (m_mode == 1) && ((m_ring_cyc / BH) % 2 == 0);
`else
        e.buzz = (m_mode == 1);
`endif
        return e;
    endfunction

    // Inputs change on the falling edge; the expected post-edge outputs are queued.
    task automatic drive(input bit r, input bit b, input bit t, input bit s, input bit d);
        reset    = r;
        buzz_req = b;
        tick_1hz = t;
        snooze   = s;
        dismiss  = d;
        model_step(r, b, t, s, d);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic ring_secs(input int n, input bit b);
        for (int i = 0; i < n; i++) begin
            drive(0, b, 1, 0, 0);
            drive(0, b, 0, 0, 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {state, buzzer_out, ringing, dismiss_ack, snooze_count};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got st=%0d buzz=%0b ring=%0b ack=%0b cnt=%0d need st=%0d buzz=%0b ring=%0b ack=%0b cnt=%0d",
                             $time, got.st, got.buzz, got.ring, got.ack, got.cnt,
                             e.st, e.buzz, e.ring, e.ack, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        bit b;
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 1, 1, 1);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0);
        // Ring and watch the beep pattern
        repeat (14) drive(0, 1, 0, 0, 0);
        // Snooze, snooze-while-snoozing, expiry back to RING
        drive(0, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        ring_secs(3, 1);
        drive(0, 1, 0, 1, 0);
        ring_secs(3, 1);
        drive(0, 1, 0, 1, 0);
        // Count saturated: timeout goes to DONE; inputs in DONE ignored
        ring_secs(5, 1);
        drive(0, 1, 0, 1, 1);
        drive(0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // Simultaneous snooze and dismiss
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0);
        // Tick together with dismiss, on the timeout second
        drive(0, 1, 0, 0, 0);
        ring_secs(4, 1);
        drive(0, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0);
        // Timeout with snoozes left goes to SNOOZE; buzz_req dropped there ends in IDLE
        drive(0, 1, 0, 0, 0);
        ring_secs(5, 1);
        ring_secs(3, 0);
        drive(0, 0, 0, 0, 0);
        // Reset mid-RING, buzz_req still high
        repeat (5) drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        repeat (3) drive(0, 1, 0, 0, 0);
        // Randomised traffic
        b = 1;
        repeat (4000) begin
            if ($urandom_range(0, 199) == 0) b = !b;
            drive($urandom_range(0, 699) == 0, b,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 59) == 0);
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d need=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
